// File: rtl/pulse_train_scheduler.sv
// Pulse train scheduler: trains of fixed-width pulses separated by programmable low gaps.
// Define PTS_RANDOM_SPACING_EN to draw each gap from [min_gap, max_gap] using a 32-bit LFSR.
module pulse_train_scheduler #(
   parameter int unsigned g_cnt_width = 16,
   parameter int unsigned g_num_width = 16,
   parameter logic [31:0] g_seed      = 32'hACE1_2024
) (
   input  logic                   clk_sys_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [g_cnt_width-1:0] width_i,
   input  logic [g_cnt_width-1:0] min_gap_i,
   input  logic [g_cnt_width-1:0] max_gap_i,
   input  logic [g_num_width-1:0] count_i,
   output logic                   pulse_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   cfg_err_o,
   output logic [g_num_width-1:0] pulses_sent_o
);

   localparam logic [g_cnt_width-1:0] CntOne = {{(g_cnt_width-1){1'b0}}, 1'b1};
   localparam logic [g_num_width-1:0] NumOne = {{(g_num_width-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

   state_e                 state_q, state_d;
   logic [g_cnt_width-1:0] width_q, width_d, min_gap_q, min_gap_d, timer_q, timer_d, gap;
   logic [g_num_width-1:0] count_q, count_d, sent_q, sent_d;
   logic                   pulse_q, pulse_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                   cfg_load, cfg_bad;

   assign cfg_load = (state_q == StIdle) && start_i && !abort_i;

`ifdef PTS_RANDOM_SPACING_EN
   // x^32+x^22+x^2+x+1 in right-shifting Galois form
   localparam logic [31:0] LfsrTaps = 32'h8020_0003;

   logic [g_cnt_width-1:0] max_gap_q, range, mask, offs;
   logic [31:0]            lfsr_q;
   logic                   gap_enter;

   assign cfg_bad   = (width_i == '0) || (min_gap_i == '0) || (max_gap_i < min_gap_i);
   assign gap_enter = (state_q == StPulse) && (state_d == StGap);

   // Mask the LFSR to the smallest 2^k-1 covering the range, then fold any overshoot back.
   always_comb begin
      range = max_gap_q - min_gap_q;
      mask  = '0;
      for (int unsigned i = 0; i < g_cnt_width; i++) begin
         if ((range >> i) != '0) mask[i] = 1'b1;
      end
      offs = lfsr_q[g_cnt_width-1:0] & mask;
      if (offs > range) offs = offs - (range + CntOne);
      gap = min_gap_q + offs;
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         max_gap_q <= '0;
         lfsr_q    <= g_seed;
      end else begin
         if (cfg_load)  max_gap_q <= max_gap_i;
         if (gap_enter) lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
      end
   end
`else
   logic unused_max_gap;

   assign unused_max_gap = ^max_gap_i;
   assign cfg_bad        = (width_i == '0) || (min_gap_i == '0);
   assign gap            = min_gap_q;
`endif

   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      min_gap_d = min_gap_q;
      count_d   = count_q;
      timer_d   = timer_q;
      sent_d    = sent_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_load) begin
               width_d   = width_i;
               min_gap_d = min_gap_i;
               count_d   = count_i;
               sent_d    = '0;
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StPulse;
                  timer_d = width_i - CntOne;
                  sent_d  = NumOne;
               end
            end
         end
         StPulse: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (timer_q != '0) begin
               timer_d = timer_q - CntOne;
            end else if ((count_q != '0) && (sent_q == count_q)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               state_d = StGap;
               timer_d = gap - CntOne;
            end
         end
         StGap: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (timer_q != '0) begin
               timer_d = timer_q - CntOne;
            end else begin
               state_d = StPulse;
               timer_d = width_q - CntOne;
               sent_d  = sent_q + NumOne;
            end
         end
         default: state_d = StIdle;
      endcase
      pulse_d = (state_d == StPulse);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         width_q   <= '0;
         min_gap_q <= '0;
         count_q   <= '0;
         timer_q   <= '0;
         sent_q    <= '0;
         pulse_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         min_gap_q <= min_gap_d;
         count_q   <= count_d;
         timer_q   <= timer_d;
         sent_q    <= sent_d;
         pulse_q   <= pulse_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign pulse_o       = pulse_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign cfg_err_o     = err_q;
   assign pulses_sent_o = sent_q;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Bench for pulse_train_scheduler: time-based reference model checked every cycle, plus literals.
`timescale 1ns/1ps
module tb_pulse_train_scheduler;
   localparam int unsigned CW = 16;
   localparam int unsigned NW = 16;
   localparam logic [31:0] Seed = 32'hACE1_2024;
   // Coefficients x^32, x^22, x^2, x^1 land on bits 31, 21, 1, 0 when shifting toward bit 0
   localparam logic [31:0] PolyMask = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [CW-1:0] width = '0, min_gap = '0, max_gap = '0;
   logic [NW-1:0] count = '0;
   logic          pulse, busy, done, cfg_err;
   logic [NW-1:0] sent;

   always #5 clk = ~clk;

   pulse_train_scheduler #(.g_cnt_width(CW), .g_num_width(NW), .g_seed(Seed)) dut (
      .clk_sys_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
      .width_i(width), .min_gap_i(min_gap), .max_gap_i(max_gap), .count_i(count),
      .pulse_o(pulse), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
      .pulses_sent_o(sent)
   );

   int n_cmp = 0, n_bad = 0;

   // Model: a train is described by the rise time of the current pulse and the next rise time
   int            cyc = 0, m_rise = 0, m_next = 0, m_w = 0, m_min = 0;
   bit            m_act = 0, e_done = 0, e_err = 0;
   logic [NW-1:0] m_cnt = '0, m_sent = '0;
`ifdef PTS_RANDOM_SPACING_EN
   int            m_max = 0;
   logic [31:0]   m_lfsr = Seed;
`endif

   int rise_t[$], fall_t[$], meas_gap[$];
   int done_cnt = 0, err_cnt = 0, done_bad = 0;
   bit p_pulse = 0, p_busy = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_gap();
`ifdef PTS_RANDOM_SPACING_EN
      int r, m, o;
      r = m_max - m_min;
      m = 0;
      while (m < r) m = 2 * m + 1;
      o = int'(m_lfsr[CW-1:0]) & m;
      if (o > r) o = o - (r + 1);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ PolyMask) : (m_lfsr >> 1);
      return m_min + o;
`else
      return m_min;
`endif
   endfunction

   task automatic model_reset();
      cyc = 0; m_act = 0; m_sent = '0; e_done = 0; e_err = 0; m_rise = 0; m_next = 0;
`ifdef PTS_RANDOM_SPACING_EN
      m_lfsr = Seed;
`endif
   endtask

   task automatic model_step();
      bit bad;
      cyc++;
      e_done = 0;
      e_err  = 0;
      if (!m_act) begin
         if (start && !abort) begin
            m_w = int'(width); m_min = int'(min_gap); m_cnt = count; m_sent = '0;
            bad = (width == '0) || (min_gap == '0);
`ifdef PTS_RANDOM_SPACING_EN
            m_max = int'(max_gap);
            bad   = bad || (max_gap < min_gap);
`endif
            if (bad) e_err = 1;
            else begin m_act = 1; m_rise = cyc; m_sent = NW'(1); end
         end
      end else if (abort) begin
         m_act = 0;
      end else if (cyc == m_rise + m_w) begin
         if (m_cnt != '0 && m_sent == m_cnt) begin m_act = 0; e_done = 1; end
         else m_next = cyc + model_gap();
      end else if (cyc == m_next) begin
         m_rise = cyc;
         m_sent++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic do_start(input int w, input int mn, input int mx, input int c);
      width = CW'(w); min_gap = CW'(mn); max_gap = CW'(mx); count = NW'(c);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int k = 0;
      while (busy && k < limit) begin tick(1); k++; end
      chk(name, 32'(busy), 0);
   endtask

   initial begin
      int mark, fmark, dmark, emark, gmark, k, oob;
      bit seen[4];
      fork
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
         end
         forever begin
            @(negedge clk);
            chk("pulse_o", 32'(pulse), 32'(m_act && (cyc < m_rise + m_w)));
            chk("busy_o", 32'(busy), 32'(m_act));
            chk("done_o", 32'(done), 32'(e_done));
            chk("cfg_err_o", 32'(cfg_err), 32'(e_err));
            chk("pulses_sent_o", 32'(sent), 32'(m_sent));
         end
         forever begin
            @(negedge clk);
            if (pulse && !p_pulse) begin
               rise_t.push_back(cyc);
               if (p_busy && fall_t.size() > 0) meas_gap.push_back(cyc - fall_t[$]);
            end
            if (!pulse && p_pulse) fall_t.push_back(cyc);
            if (done) begin done_cnt++; if (busy || !p_busy) done_bad++; end
            if (cfg_err) err_cnt++;
            p_pulse = pulse;
            p_busy  = busy;
         end
      join_none

      // Reset state
      tick(3);
      chk("rst_pulse", 32'(pulse), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_sent", 32'(sent), 0);
      rst_n = 1'b1;
      tick(2);

      // Fixed-spacing finite train: 4 pulses, 3 high, edges 8 apart
      mark = rise_t.size(); fmark = fall_t.size(); dmark = done_cnt;
      do_start(3, 5, 5, 4);
      chk("t35_latency", 32'(pulse && busy), 1);
      wait_idle("t35_timeout", 200);
      chk("t35_rises", 32'(rise_t.size() - mark), 4);
      if (rise_t.size() - mark == 4 && fall_t.size() - fmark == 4) begin
         for (int i = 1; i < 4; i++)
            chk("t35_spacing", 32'(rise_t[mark+i] - rise_t[mark+i-1]), 8);
         for (int i = 0; i < 4; i++)
            chk("t35_high", 32'(fall_t[fmark+i] - rise_t[mark+i]), 3);
      end
      chk("t35_done_cycles", 32'(done_cnt - dmark), 1);
      chk("t35_done_at_busy_fall", 32'(done_bad), 0);
      chk("t35_sent", 32'(sent), 4);
      tick(2);

      // Rejected configurations
      emark = err_cnt;
      do_start(0, 5, 5, 3);
      chk("t37_err_w0", 32'(cfg_err), 1);
      chk("t37_busy_w0", 32'(busy), 0);
      tick(1);
      chk("t37_err_one_cycle", 32'(cfg_err), 0);
      chk("t37_pulse_w0", 32'(pulse), 0);
      chk("t37_sent_cleared", 32'(sent), 0);
      do_start(4, 0, 5, 3);
      chk("t37_err_gap0", 32'(cfg_err), 1);
      tick(1);
      do_start(2, 7, 4, 3);
`ifdef PTS_RANDOM_SPACING_EN
      chk("t37_err_max_lt_min", 32'(cfg_err), 1);
      chk("t37_busy_max_lt_min", 32'(busy), 0);
      tick(1);
      chk("t37_err_count", 32'(err_cnt - emark), 3);
`else
      chk("t37_max_ignored", 32'(busy && pulse), 1);
      do_abort();
      chk("t37_err_count", 32'(err_cnt - emark), 2);
`endif
      chk("t37_pulse_idle", 32'(pulse), 0);
      tick(2);

      // Continuous train, abort in 2nd high cycle of 5th pulse
      dmark = done_cnt;
      do_start(3, 2, 4, 0);
      k = 0;
      while (!(pulse && sent == 5) && k < 500) begin tick(1); k++; end
      chk("t38_reach_5th", 32'(pulse && sent == 5), 1);
      tick(1);
      chk("t38_second_high", 32'(pulse), 1);
      do_abort();
      chk("t38_pulse_low", 32'(pulse), 0);
      chk("t38_busy_low", 32'(busy), 0);
      chk("t38_sent", 32'(sent), 5);
      tick(3);
      chk("t38_no_done", 32'(done_cnt - dmark), 0);
      chk("t38_sent_hold", 32'(sent), 5);

      // Start while busy is ignored; reset mid-pulse drops the output at once
      mark = rise_t.size(); fmark = fall_t.size(); emark = err_cnt;
      do_start(4, 3, 3, 0);
      tick(2);
      do_start(9, 1, 1, 2);
      tick(30);
      chk("t39_no_err", 32'(err_cnt - emark), 0);
      if (rise_t.size() - mark >= 4) begin
         chk("t39_spacing_a", 32'(rise_t[mark+1] - rise_t[mark]), 7);
         chk("t39_spacing_b", 32'(rise_t[mark+3] - rise_t[mark+2]), 7);
         chk("t39_high", 32'(fall_t[fmark+2] - rise_t[mark+2]), 4);
      end else begin
         chk("t39_rises", 32'(rise_t.size() - mark), 4);
      end
      k = 0;
      while (pulse && k < 20) begin tick(1); k++; end
      while (!pulse && k < 40) begin tick(1); k++; end
      tick(1);
      chk("t39_mid_pulse", 32'(pulse), 1);
      rst_n = 1'b0;
      #1;
      chk("t39_async_drop", 32'(pulse), 0);
      chk("t39_async_busy", 32'(busy), 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("t39_wait_idle", 32'(busy), 0);
      chk("t39_sent_reset", 32'(sent), 0);
      do_start(2, 3, 3, 2);
      chk("t39_restart_pulse", 32'(pulse), 1);
      chk("t39_restart_busy", 32'(busy), 1);
      chk("t39_restart_sent", 32'(sent), 1);
      wait_idle("t39_timeout", 100);
      chk("t39_final_sent", 32'(sent), 2);

`ifdef PTS_RANDOM_SPACING_EN
      // Random spacing from a fresh seed: gaps in [10,13], all seen, first four hand-derived
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      gmark = meas_gap.size();
      do_start(2, 10, 13, 1000);
      wait_idle("t36_timeout", 20000);
      chk("t36_sent", 32'(sent), 1000);
      chk("t36_gap_count", 32'(meas_gap.size() - gmark), 999);
      oob = 0;
      for (int i = 0; i < 4; i++) seen[i] = 0;
      for (int i = gmark; i < meas_gap.size(); i++) begin
         if (meas_gap[i] < 10 || meas_gap[i] > 13) oob++;
         else seen[meas_gap[i] - 10] = 1;
      end
      chk("t36_out_of_range", 32'(oob), 0);
      chk("t36_all_seen", 32'(seen[0] && seen[1] && seen[2] && seen[3]), 1);
      if (meas_gap.size() - gmark >= 4) begin
         chk("t36_gap0", 32'(meas_gap[gmark]), 10);
         chk("t36_gap1", 32'(meas_gap[gmark+1]), 12);
         chk("t36_gap2", 32'(meas_gap[gmark+2]), 11);
         chk("t36_gap3", 32'(meas_gap[gmark+3]), 13);
      end
`endif

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_train_scheduler.md
PULSE_TRAIN_SCHEDULER -- requirements
Module: pulse_train_scheduler

Interface
REQ-001 The module SHALL have parameter g_cnt_width, default 16, giving the width of all cycle-count fields.
REQ-002 The module SHALL have parameter g_num_width, default 16, giving the width of the pulse-count fields.
REQ-003 The module SHALL have parameter g_seed, default 32'hACE1_2024, giving the non-zero LFSR reset value.
REQ-004 clk_sys_i  in  1  system clock; all logic is on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  one-cycle request to begin a pulse train.
REQ-007 abort_i  in  1  one-cycle request to stop the train immediately.
REQ-008 width_i  in  g_cnt_width  pulse high time, in cycles.
REQ-009 min_gap_i  in  g_cnt_width  minimum low time between pulses, in cycles.
REQ-010 max_gap_i  in  g_cnt_width  maximum low time between pulses, in cycles.
REQ-011 count_i  in  g_num_width  number of pulses; 0 means continuous.
REQ-012 pulse_o  out  1  generated pulse train, registered.
REQ-013 busy_o  out  1  high while a train is active.
REQ-014 done_o  out  1  one-cycle strobe when a finite train completes.
REQ-015 cfg_err_o  out  1  one-cycle strobe when a start request is rejected.
REQ-016 pulses_sent_o  out  g_num_width  number of pulses started in the current or last train.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, PULSE and GAP.
REQ-018 In IDLE, start_i=1 with abort_i=0 SHALL latch width_i, min_gap_i, max_gap_i and count_i, and SHALL clear pulses_sent_o.
- Config inputs SHALL be ignored at all other times.
REQ-019 At the start request, the latched config SHALL be rejected if width=0, min_gap=0, or max_gap<min_gap.
- On rejection, cfg_err_o SHALL be 1 for the next cycle and the FSM SHALL stay in IDLE.
REQ-020 An accepted start SHALL enter PULSE, with pulse_o=1 and busy_o=1 from the next cycle (latency 1).
REQ-021 In PULSE, pulse_o SHALL stay high for exactly width cycles.
- pulses_sent_o SHALL increment in the first high cycle, wrapping modulo 2^g_num_width.
REQ-022 When the PULSE time ends with count!=0 and pulses_sent_o=count:
- the FSM SHALL go to IDLE, with pulse_o=0 and busy_o=0;
- done_o SHALL be 1 for that one cycle.
REQ-023 Otherwise, when the PULSE time ends, the FSM SHALL enter GAP with pulse_o=0 for exactly gap cycles, then return to PULSE.
- Rising edges of pulse_o SHALL therefore be exactly width+gap cycles apart.
REQ-024 The gap length SHALL be computed once, on entry to GAP.
REQ-025 Gap selection: r = max_gap - min_gap; m = smallest all-ones mask >= r; o = lfsr[g_cnt_width-1:0] & m; if o>r then o = o-(r+1); gap = min_gap + o.
- gap SHALL always lie in [min_gap, max_gap].
REQ-026 The LFSR SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, advanced exactly once per GAP entry.
REQ-027 abort_i=1 SHALL override all other inputs in every state.
- From the next cycle: pulse_o=0, busy_o=0, FSM in IDLE, no done_o.
- A pulse in progress SHALL be truncated.
- pulses_sent_o SHALL hold its value.
REQ-028 start_i while busy_o=1 SHALL be ignored, and cfg_err_o SHALL NOT be raised.
REQ-029 start_i and abort_i together in IDLE SHALL be ignored.
REQ-030 With count=0 the train SHALL run until abort_i, and done_o SHALL never assert.

Reset
REQ-031 While rst_n_i=0 the module SHALL hold:
- pulse_o, busy_o, done_o, cfg_err_o = 0;
- pulses_sent_o = 0;
- FSM in IDLE;
- LFSR = g_seed.
REQ-032 Reset assertion mid-train SHALL drop pulse_o asynchronously.
- After release, the module SHALL wait in IDLE for a new start_i.

Configuration
REQ-033 With PTS_RANDOM_SPACING_EN defined, gap selection SHALL follow REQ-025/026.
REQ-034 Without PTS_RANDOM_SPACING_EN:
- gap SHALL equal min_gap;
- max_gap_i SHALL be ignored and excluded from the REQ-019 check;
- no LFSR SHALL be instantiated.

Verification
REQ-035 Without the macro: width=3, min_gap=5, count=4 -> 4 pulses, each 3 cycles high, rising edges 8 cycles apart; done_o one cycle, coincident with busy_o falling; pulses_sent_o=4.
REQ-036 With the macro: width=2, min_gap=10, max_gap=13, count=1000 -> every gap in [10,13], all four values seen, sequence matches a reference LFSR model from g_seed.
REQ-037 width=0, or min_gap=7 with max_gap=4 (macro on) -> cfg_err_o one cycle, busy_o stays 0, pulse_o stays 0.
REQ-038 count=0, abort_i in the 2nd high cycle of the 5th pulse -> pulse_o low the next cycle, busy_o=0, done_o never asserted, pulses_sent_o=5.
REQ-039 start_i while busy -> train unaffected; rst_n_i low mid-pulse -> pulse_o=0 immediately; after release, a new start behaves per REQ-020.
